// File: rtl/fwd_pkg.sv
// fwd_pkg: forwarding-stage types; the descriptor carries a fixed-width port field
// so one struct serves every NUM_PORTS up to 256.
package fwd_pkg;
    import mem_pkg::*;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOOKUP   = 2'd1,
        DISPATCH = 2'd2
    } fwd_state_t;

    localparam int GROUP_BIT  = 40;
    localparam int FWD_PORT_W = 8;

    typedef struct packed {
        logic [ADDR_W-1:0]     start_ptr;
        logic [47:0]           dest_addr;
        logic [FWD_PORT_W-1:0] src_port;
    } fwd_desc_t;
endpackage

// File: rtl/mem_pkg.sv
// mem_pkg: packet-memory addressing shared by the buffer, forwarding and queue stages.
package mem_pkg;
    localparam int ADDR_W = 16;
endpackage

// File: rtl/desc_fifo.sv
// desc_fifo: power-of-two descriptor queue, no bypass; ready_o is registered
// from the next occupancy so it is low exactly while the queue is full.
module desc_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic             ready_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ready_q, ready_d;

    // Next pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        ready_d = (count_d != CW'(DEPTH));
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
            ready_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
        end
    end

    // Entry storage needs no reset: only entries counted as occupied are read.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == {CW{1'b0}});
    assign ready_o = ready_q;
endmodule

// File: rtl/forward_engine.sv
// forward_engine: queues descriptors, resolves destination MACs into per-port write masks
// and holds write requests until acked. Define FWD_STATS_EN to add saturating counters.
module forward_engine
    import mem_pkg::*;
    import fwd_pkg::*;
#(
    parameter int NUM_PORTS      = 4,
    parameter int DESC_DEPTH     = 4,
    parameter int LOOKUP_TIMEOUT = 8,
    localparam int PORT_W        = $clog2(NUM_PORTS)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        desc_valid_i,
    output logic                        desc_ready_o,
    input  logic [ADDR_W-1:0]           desc_start_ptr_i,
    input  logic [47:0]                 desc_dest_addr_i,
    input  logic [PORT_W-1:0]           desc_src_port_i,
    output logic                        lookup_req_o,
    output logic [47:0]                 lookup_addr_o,
    input  logic                        lookup_valid_i,
    input  logic                        lookup_hit_i,
    input  logic [PORT_W-1:0]           lookup_port_i,
    output logic [NUM_PORTS-1:0]        write_reqs_o,
    input  logic [NUM_PORTS-1:0]        write_acks_i,
    output logic [NUM_PORTS*ADDR_W-1:0] start_ptrs_o,
    output logic                        drop_o,
    output logic [ADDR_W-1:0]           drop_ptr_o
`ifdef FWD_STATS_EN
    ,
    output logic [31:0]                 unicast_cnt_o,
    output logic [31:0]                 flood_cnt_o,
    output logic [31:0]                 drop_cnt_o
`endif
);
    localparam int TW = $clog2(LOOKUP_TIMEOUT + 1);
    localparam int DW = $bits(fwd_desc_t);

    // A zero result means the port number is outside the switch.
    function automatic logic [NUM_PORTS-1:0] port_bit(input logic [FWD_PORT_W-1:0] p);
        return {{(NUM_PORTS-1){1'b0}}, 1'b1} << p;
    endfunction

    fwd_desc_t              push_desc_s, head_s;
    logic                   push_s, pop_s, fifo_empty_s;
    logic                   uni_inc_s, flood_inc_s;
    logic [NUM_PORTS-1:0]   head_bit_s, cur_bit_s, rsp_bit_s;

    fwd_state_t                  state_q, state_d;
    fwd_desc_t                   cur_q, cur_d;
    logic [NUM_PORTS-1:0]        pending_q, pending_d;
    logic [TW-1:0]               tmo_q, tmo_d;
    logic                        lookup_req_q, lookup_req_d;
    logic [47:0]                 lookup_addr_q, lookup_addr_d;
    logic                        drop_q, drop_d;
    logic [ADDR_W-1:0]           drop_ptr_q, drop_ptr_d;
    logic [NUM_PORTS*ADDR_W-1:0] start_ptrs_q, start_ptrs_d;

    assign push_s      = desc_valid_i && desc_ready_o;
    assign push_desc_s = '{start_ptr: desc_start_ptr_i,
                           dest_addr: desc_dest_addr_i,
                           src_port:  FWD_PORT_W'(desc_src_port_i)};
    assign head_bit_s  = port_bit(head_s.src_port);
    assign cur_bit_s   = port_bit(cur_q.src_port);
    assign rsp_bit_s   = port_bit(FWD_PORT_W'(lookup_port_i));

    desc_fifo #(
        .WIDTH (DW),
        .DEPTH (DESC_DEPTH)
    ) u_desc_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_s),
        .data_i  (push_desc_s),
        .pop_i   (pop_s),
        .data_o  (head_s),
        .empty_o (fifo_empty_s),
        .ready_o (desc_ready_o)
    );

    // Next-state and next-output logic for the pop / lookup / dispatch sequence.
    always_comb begin
        state_d       = state_q;
        cur_d         = cur_q;
        pending_d     = pending_q;
        tmo_d         = tmo_q;
        lookup_req_d  = 1'b0;
        lookup_addr_d = lookup_addr_q;
        drop_d        = 1'b0;
        drop_ptr_d    = drop_ptr_q;
        pop_s         = 1'b0;
        uni_inc_s     = 1'b0;
        flood_inc_s   = 1'b0;
        start_ptrs_d  = {(NUM_PORTS*ADDR_W){1'b0}};
        case (state_q)
            IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s = 1'b1;
                    cur_d = head_s;
                    if (head_bit_s == {NUM_PORTS{1'b0}}) begin
                        drop_d     = 1'b1;
                        drop_ptr_d = head_s.start_ptr;
                        state_d    = IDLE;
                    end else if (head_s.dest_addr[GROUP_BIT]) begin
                        pending_d   = ~head_bit_s;
                        flood_inc_s = 1'b1;
                        state_d     = DISPATCH;
                    end else begin
                        lookup_req_d  = 1'b1;
                        lookup_addr_d = head_s.dest_addr;
                        tmo_d         = {TW{1'b0}};
                        state_d       = LOOKUP;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            LOOKUP: begin
                tmo_d = tmo_q + TW'(1);
                // tmo_q == 0 is the request cycle, where a response is not yet legal.
                if ((tmo_q != {TW{1'b0}}) && lookup_valid_i) begin
                    if (!lookup_hit_i) begin
                        pending_d   = ~cur_bit_s;
                        flood_inc_s = 1'b1;
                        state_d     = DISPATCH;
                    end else if ((rsp_bit_s == {NUM_PORTS{1'b0}}) || (rsp_bit_s == cur_bit_s)) begin
                        drop_d     = 1'b1;
                        drop_ptr_d = cur_q.start_ptr;
                        state_d    = IDLE;
                    end else begin
                        pending_d = rsp_bit_s;
                        uni_inc_s = 1'b1;
                        state_d   = DISPATCH;
                    end
                end else if (tmo_q == TW'(LOOKUP_TIMEOUT)) begin
                    pending_d   = ~cur_bit_s;
                    flood_inc_s = 1'b1;
                    state_d     = DISPATCH;
                end else begin
                    state_d = LOOKUP;
                end
            end
            DISPATCH: begin
                pending_d = pending_q & ~write_acks_i;
                if (pending_d == {NUM_PORTS{1'b0}}) begin
                    state_d = IDLE;
                end else begin
                    state_d = DISPATCH;
                end
            end
            default: begin
                pending_d = {NUM_PORTS{1'b0}};
                state_d   = IDLE;
            end
        endcase
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (pending_d[i]) begin
                start_ptrs_d[i*ADDR_W +: ADDR_W] = cur_d.start_ptr;
            end else begin
                start_ptrs_d[i*ADDR_W +: ADDR_W] = {ADDR_W{1'b0}};
            end
        end
    end

    // Engine state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cur_q         <= '{start_ptr: {ADDR_W{1'b0}}, dest_addr: 48'd0, src_port: {FWD_PORT_W{1'b0}}};
            pending_q     <= {NUM_PORTS{1'b0}};
            tmo_q         <= {TW{1'b0}};
            lookup_req_q  <= 1'b0;
            lookup_addr_q <= 48'd0;
            drop_q        <= 1'b0;
            drop_ptr_q    <= {ADDR_W{1'b0}};
            start_ptrs_q  <= {(NUM_PORTS*ADDR_W){1'b0}};
        end else begin
            state_q       <= state_d;
            cur_q         <= cur_d;
            pending_q     <= pending_d;
            tmo_q         <= tmo_d;
            lookup_req_q  <= lookup_req_d;
            lookup_addr_q <= lookup_addr_d;
            drop_q        <= drop_d;
            drop_ptr_q    <= drop_ptr_d;
            start_ptrs_q  <= start_ptrs_d;
        end
    end

    assign lookup_req_o  = lookup_req_q;
    assign lookup_addr_o = lookup_addr_q;
    assign write_reqs_o  = pending_q;
    assign start_ptrs_o  = start_ptrs_q;
    assign drop_o        = drop_q;
    assign drop_ptr_o    = drop_ptr_q;

`ifdef FWD_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
    endfunction

    logic [31:0] uni_cnt_q, uni_cnt_d;
    logic [31:0] flood_cnt_q, flood_cnt_d;
    logic [31:0] drop_cnt_q, drop_cnt_d;

    // Saturating event counters.
    always_comb begin
        uni_cnt_d   = sat_inc(uni_cnt_q, uni_inc_s);
        flood_cnt_d = sat_inc(flood_cnt_q, flood_inc_s);
        drop_cnt_d  = sat_inc(drop_cnt_q, drop_d);
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uni_cnt_q   <= 32'd0;
            flood_cnt_q <= 32'd0;
            drop_cnt_q  <= 32'd0;
        end else begin
            uni_cnt_q   <= uni_cnt_d;
            flood_cnt_q <= flood_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign unicast_cnt_o = uni_cnt_q;
    assign flood_cnt_o   = flood_cnt_q;
    assign drop_cnt_o    = drop_cnt_q;
`else
    logic unused_stats_s;
    assign unused_stats_s = uni_inc_s ^ flood_inc_s;
`endif
endmodule

// File: tb/tb_forward_engine.sv
// tb_forward_engine: directed and randomized descriptors checked against a rule-level
// model of the forwarding decision, its cycle timing and the ack-driven request lifetime.
module tb_forward_engine;
    import mem_pkg::*;

    localparam int NP = 4;
    localparam int T  = 8;
    localparam int PW = ADDR_W * NP;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              desc_valid;
    logic              desc_ready;
    logic [ADDR_W-1:0] desc_ptr;
    logic [47:0]       desc_dest;
    logic [1:0]        desc_src;
    logic              lookup_req;
    logic [47:0]       lookup_addr;
    logic              lookup_valid;
    logic              lookup_hit;
    logic [1:0]        lookup_port;
    logic [NP-1:0]     write_reqs;
    logic [NP-1:0]     write_acks;
    logic [PW-1:0]     start_ptrs;
    logic              drop;
    logic [ADDR_W-1:0] drop_ptr;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    forward_engine #(
        .NUM_PORTS      (NP),
        .DESC_DEPTH     (4),
        .LOOKUP_TIMEOUT (T)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .desc_valid_i     (desc_valid),
        .desc_ready_o     (desc_ready),
        .desc_start_ptr_i (desc_ptr),
        .desc_dest_addr_i (desc_dest),
        .desc_src_port_i  (desc_src),
        .lookup_req_o     (lookup_req),
        .lookup_addr_o    (lookup_addr),
        .lookup_valid_i   (lookup_valid),
        .lookup_hit_i     (lookup_hit),
        .lookup_port_i    (lookup_port),
        .write_reqs_o     (write_reqs),
        .write_acks_i     (write_acks),
        .start_ptrs_o     (start_ptrs),
        .drop_o           (drop),
        .drop_ptr_o       (drop_ptr)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NP-1:0] flood_of(input int src);
        logic [NP-1:0] m;
        m = {NP{1'b1}};
        m[src] = 1'b0;
        return m;
    endfunction

    function automatic logic [PW-1:0] ptrs_of(input logic [NP-1:0] mask, input logic [ADDR_W-1:0] ptr);
        logic [PW-1:0] v;
        v = '0;
        for (int i = 0; i < NP; i++) begin
            if (mask[i]) v[i*ADDR_W +: ADDR_W] = ptr;
        end
        return v;
    endfunction

    // One descriptor from push to completion with an idle engine. d = lookup response
    // delay after the request cycle; d > T means no response before the timeout and a
    // late one afterwards. ack_off holds one 4-bit ack cycle per port, counted from dispatch.
    task automatic run_txn(input logic [ADDR_W-1:0] ptr, input logic [47:0] dest, input int src,
                           input bit hit, input int port, input int d, input bit junk,
                           input logic [15:0] ack_off);
        bit            grp;
        bit            exp_drop;
        logic [NP-1:0] exp_mask;
        logic [NP-1:0] pend;
        logic [NP-1:0] acks;
        int            r;
        grp      = dest[40];
        exp_drop = 1'b0;
        if (grp || !hit || d > T) begin
            exp_mask = flood_of(src);
        end else if (port == src) begin
            exp_drop = 1'b1;
            exp_mask = '0;
        end else begin
            exp_mask = NP'(1) << port;
        end

        desc_valid = 1'b1;
        desc_ptr   = ptr;
        desc_dest  = dest;
        desc_src   = 2'(src);
        tick();
        desc_valid = 1'b0;
        tick();
        if (grp) begin
            chk("grp_no_lookup", lookup_req, 1'b0);
        end else begin
            chk("lookup_req", lookup_req, 1'b1);
            chk("lookup_addr", lookup_addr, dest);
            chk("req_no_write", write_reqs, 0);
            if (junk) begin
                lookup_valid = 1'b1;
                lookup_hit   = 1'b0;
                lookup_port  = 2'd0;
            end
            r = (d <= T) ? d : T;
            for (int k = 1; k <= r; k++) begin
                tick();
                lookup_valid = 1'b0;
                chk("req_one_cycle", lookup_req, 1'b0);
                chk("wait_no_write", write_reqs, 0);
                chk("wait_no_drop", drop, 1'b0);
                if (k == d) begin
                    lookup_valid = 1'b1;
                    lookup_hit   = hit;
                    lookup_port  = 2'(port);
                end
            end
            tick();
            lookup_valid = 1'b0;
        end

        if (exp_drop) begin
            chk("drop_pulse", drop, 1'b1);
            chk("drop_ptr", drop_ptr, ptr);
            chk("drop_no_write", write_reqs, 0);
            tick();
            chk("drop_one_cycle", drop, 1'b0);
            chk("drop_still_no_write", write_reqs, 0);
            return;
        end

        chk("dispatch_no_drop", drop, 1'b0);
        pend = exp_mask;
        for (int j = 0; j < 20; j++) begin
            chk("write_reqs", write_reqs, pend);
            chk("start_ptrs", start_ptrs, ptrs_of(pend, ptr));
            if (pend == '0) break;
            for (int i = 0; i < NP; i++) begin
                if (pend[i]) acks[i] = (ack_off[4*i +: 4] == 4'(j));
                else         acks[i] = 1'($urandom_range(0, 1));
            end
            write_acks = acks;
            if (!grp && d > T && j == d - T - 1) begin
                lookup_valid = 1'b1;
                lookup_hit   = 1'b1;
                lookup_port  = 2'($urandom_range(0, 3));
            end
            tick();
            write_acks   = '0;
            lookup_valid = 1'b0;
            pend         = pend & ~acks;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, desc_ready, 1'b1);
        chk({tag, "_lookup_req"}, lookup_req, 1'b0);
        chk({tag, "_lookup_addr"}, lookup_addr, 0);
        chk({tag, "_write_reqs"}, write_reqs, 0);
        chk({tag, "_start_ptrs"}, start_ptrs, 0);
        chk({tag, "_drop"}, drop, 1'b0);
        chk({tag, "_drop_ptr"}, drop_ptr, 0);
    endtask

    initial begin
        logic [47:0] dest;
        int          occ;
        bit          exp_ready;

        rst_n        = 1'b0;
        desc_valid   = 1'b0;
        desc_ptr     = '0;
        desc_dest    = '0;
        desc_src     = '0;
        lookup_valid = 1'b0;
        lookup_hit   = 1'b0;
        lookup_port  = '0;
        write_acks   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        tick();
        tick();

        // Unicast hit to port 2.
        run_txn(16'h0010, 48'h0011_2233_4455, 0, 1'b1, 2, 1, 1'b0, 16'h0000);
        // Miss from port 1 floods 1101; acks port0 +1, port2 +3, port3 +5.
        run_txn(16'h0020, 48'h0A0B_0C0D_0E0F, 1, 1'b0, 0, 1, 1'b0, 16'h5301);
        // Broadcast from port 3: no lookup, 0111 two cycles after push.
        run_txn(16'h0030, 48'hFFFF_FFFF_FFFF, 3, 1'b0, 0, 1, 1'b0, 16'h0120);
        // Hit back to the ingress port is dropped.
        run_txn(16'h0040, 48'h0200_0000_0002, 2, 1'b1, 2, 2, 1'b1, 16'h0000);
        // Timeouts, with late responses landing in dispatch.
        run_txn(16'h0050, 48'h00AA_BBCC_DDEE, 0, 1'b1, 3, T + 1, 1'b0, 16'h1111);
        run_txn(16'h0051, 48'h00AA_BBCC_DDEF, 3, 1'b1, 1, T + 2, 1'b0, 16'h0203);
        // Response on the last legal cycle, with junk during the request cycle.
        run_txn(16'h0060, 48'h0012_3456_789A, 1, 1'b1, 3, T, 1'b1, 16'h2000);

        for (int n = 0; n < 24; n++) begin
            dest = {16'($urandom), 32'($urandom)};
            dest[40] = ($urandom_range(0, 2) == 0);
            run_txn(16'($urandom), dest, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 3)), int'($urandom_range(1, T + 2)),
                    1'($urandom_range(0, 1)), 16'($urandom_range(0, 16'h4444)));
        end

        // Backpressure: acks held low, the first descriptor stalls in dispatch.
        occ = 0;
        for (int k = 0; k < 7; k++) begin
            desc_valid = 1'b1;
            desc_ptr   = 16'h0100 + 16'(k);
            desc_dest  = 48'hFFFF_FFFF_FFFF;
            desc_src   = 2'd0;
            exp_ready  = (occ < 4);
            chk("bp_ready", desc_ready, exp_ready);
            if (k == 2) chk("bp_first_dispatch", write_reqs, 4'b1110);
            tick();
            if (exp_ready) occ++;
            if (k == 1) occ--;
        end
        desc_valid = 1'b0;
        chk("bp_still_pending", write_reqs, 4'b1110);
        chk("bp_ptrs", start_ptrs, ptrs_of(4'b1110, 16'h0100));

        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("post_reset_idle_write", write_reqs, 0);
            chk("post_reset_idle_lookup", lookup_req, 1'b0);
            chk("post_reset_idle_drop", drop, 1'b0);
            chk("post_reset_ready", desc_ready, 1'b1);
        end
        run_txn(16'h0070, 48'h0011_2233_4455, 3, 1'b1, 0, 1, 1'b0, 16'h0002);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
